// File: rtl/regfile_sb.sv
// regfile_sb: XLEN x NREGS register file with a busy scoreboard for
// long-latency (mul/div) writeback.
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   rsN_addr/rd_en/data/busy  two combinational read ports with busy flags
//   wa_*                      port A, single-cycle ALU writeback
//   wl_*                      port L, long-op writeback (clears busy)
//   iss_en, iss_rd            long-op issue (sets busy)
//   rd_hazard                 WAW hazard toward the issue stage (combinational)
//   waw_err                   registered one-cycle error pulse
//   busy_vec                  scoreboard bits
module regfile_sb #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned INIT_INDEX = 0,
    localparam int unsigned AW        = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_addr,
    input  logic             rs1_rd_en,
    output logic [XLEN-1:0]  rs1_data,
    output logic             rs1_busy,
    input  logic [AW-1:0]    rs2_addr,
    input  logic             rs2_rd_en,
    output logic [XLEN-1:0]  rs2_data,
    output logic             rs2_busy,
    input  logic             wa_en,
    input  logic [AW-1:0]    wa_addr,
    input  logic [XLEN-1:0]  wa_data,
    input  logic             wl_en,
    input  logic [AW-1:0]    wl_addr,
    input  logic [XLEN-1:0]  wl_data,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    output logic             rd_hazard,
    output logic             waw_err,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             r_waw_err;
    logic             w_collide;
    logic             w_spurious;

    // Read mux: x0/disabled read zero, optional same-cycle bypass (port A first).
    function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0] a, input logic en);
        logic [XLEN-1:0] d;
        d = '0;
        if (en && (a != '0)) begin
            d = r_regs[a];
            if (BYPASS != 0) begin
                if (wa_en && (wa_addr == a)) begin
                    d = wa_data;
                end else if (wl_en && (wl_addr == a)) begin
                    d = wl_data;
                end
            end
        end
        return d;
    endfunction

    always_comb begin
        rs1_data = f_read(rs1_addr, rs1_rd_en);
        rs2_data = f_read(rs2_addr, rs2_rd_en);
    end

    // busy[0] is held at 0, so x0 never reports busy.
    assign rs1_busy = r_busy[rs1_addr] & rs1_rd_en;
    assign rs2_busy = r_busy[rs2_addr] & rs2_rd_en;

    // Hazard: issuing onto, or ALU-writing, a register with a pending long op.
    assign rd_hazard = (iss_en & r_busy[iss_rd]) | (wa_en & r_busy[wa_addr]);

    // Error sources: both write ports on one register, or writeback with no pending op.
    assign w_collide  = wa_en && wl_en && (wa_addr == wl_addr) && (wa_addr != '0);
    assign w_spurious = wl_en && (wl_addr != '0) && !r_busy[wl_addr];

    // Register contents, scoreboard and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs[0] <= '0;
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= (INIT_INDEX != 0) ? XLEN'(i) : '0;
            end
            r_busy    <= '0;
            r_waw_err <= 1'b0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wa_en && (wa_addr == AW'(i))) begin
                    r_regs[i] <= wa_data;
                end else if (wl_en && (wl_addr == AW'(i))) begin
                    r_regs[i] <= wl_data;
                end
                // Issue-set wins over a same-edge writeback clear.
                if (iss_en && (iss_rd == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (wl_en && (wl_addr == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            r_busy[0] <= 1'b0;
            r_waw_err <= w_collide | w_spurious;
        end
    end

    assign waw_err  = r_waw_err;
    assign busy_vec = r_busy;

endmodule
